// File: rtl/vmac_pkg.sv
// Shared types and helpers for the vector multiply-accumulate pipe.
// Optional signed saturation is enabled by defining VMAC_SAT_EN.
package vmac_pkg;

  localparam int unsigned MAX_SEW = 32;

  typedef enum logic [1:0] {
    SEW8     = 2'd0,
    SEW16    = 2'd1,
    SEW32    = 2'd2,
    SEW_RSVD = 2'd3
  } sew_e;

  typedef enum logic {
    VMACC  = 1'b0,
    VNMSAC = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned sew_bits(input sew_e s);
    case (s)
      SEW8:    return 8;
      SEW16:   return 16;
      default: return 32;
    endcase
  endfunction

  function automatic logic [MAX_SEW-1:0] sew_mask(input int unsigned w);
    if (w >= MAX_SEW) return '1;
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/vmac_lane.sv
// One 32-bit slice of SEW-partitioned multiply-add; purely combinational.
// With VMAC_SAT_EN defined, elements are signed and results saturate.
module vmac_lane
  import vmac_pkg::*;
(
  input  logic [MAX_SEW-1:0] a_i,
  input  logic [MAX_SEW-1:0] b_i,
  input  logic [MAX_SEW-1:0] c_i,
  input  sew_e               sew_i,
  input  op_e                op_i,
  output logic [MAX_SEW-1:0] res_o
`ifdef VMAC_SAT_EN
  ,
  output logic               sat_o
`endif
);

`ifdef VMAC_SAT_EN
  // Full-precision signed c +/- a*b clamped to the SEW range; bit 32 flags saturation.
  function automatic logic [MAX_SEW:0] mac_sat(input logic [MAX_SEW-1:0] a, b, c,
                                               input int unsigned w, input logic sub);
    logic signed [MAX_SEW-1:0] sa, sb, sc;
    logic signed [65:0] xa, xb, xc, full, hi, lo;
    int unsigned sh;
    sh   = MAX_SEW - w;
    sa   = $signed(a << sh) >>> sh;
    sb   = $signed(b << sh) >>> sh;
    sc   = $signed(c << sh) >>> sh;
    xa   = sa;
    xb   = sb;
    xc   = sc;
    full = sub ? (xc - xa * xb) : (xc + xa * xb);
    hi   = (66'sd1 <<< (w - 1)) - 66'sd1;
    lo   = -(66'sd1 <<< (w - 1));
    if (full > hi) return {1'b1, hi[MAX_SEW-1:0]};
    if (full < lo) return {1'b1, lo[MAX_SEW-1:0]};
    return {1'b0, full[MAX_SEW-1:0]};
  endfunction
`else
  function automatic logic [MAX_SEW-1:0] mac_wrap(input logic [MAX_SEW-1:0] a, b, c,
                                                  input int unsigned w, input logic sub);
    logic [MAX_SEW-1:0] p;
    p = a * b;
    return (sub ? (c - p) : (c + p)) & sew_mask(w);
  endfunction
`endif

  int unsigned        w;
  logic [MAX_SEW-1:0] mask, ea, eb, ec, er;
`ifdef VMAC_SAT_EN
  logic [MAX_SEW:0]   e;
`endif

  // Each element is extracted, computed and re-inserted in isolation, so no carry crosses SEW.
  always_comb begin
    w     = sew_bits(sew_i);
    mask  = sew_mask(w);
    res_o = '0;
    ea    = '0;
    eb    = '0;
    ec    = '0;
    er    = '0;
`ifdef VMAC_SAT_EN
    e     = '0;
    sat_o = 1'b0;
`endif
    for (int unsigned i = 0; i < MAX_SEW / 8; i++) begin
      if (i * w < MAX_SEW) begin
        ea = (a_i >> (i * w)) & mask;
        eb = (b_i >> (i * w)) & mask;
        ec = (c_i >> (i * w)) & mask;
`ifdef VMAC_SAT_EN
        e     = mac_sat(ea, eb, ec, w, op_i == VNMSAC);
        er    = e[MAX_SEW-1:0];
        sat_o = sat_o | e[MAX_SEW];
`else
        er = mac_wrap(ea, eb, ec, w, op_i == VNMSAC);
`endif
        res_o = res_o | ((er & mask) << (i * w));
      end
    end
  end

endmodule

// File: rtl/vmac_pipe.sv
// Multi-beat vector multiply-accumulate: IDLE -> BUSY (BEATS slices) -> DONE.
// Define VMAC_SAT_EN for signed saturating arithmetic and the sat_o output.
module vmac_pipe
  import vmac_pkg::*;
#(
  parameter int unsigned VLEN          = 256,
  parameter int unsigned BEATS         = 4,
  parameter int unsigned ELEMENT_WIDTH = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  output logic            ready_o,
  input  logic [1:0]      sew_i,
  input  logic            op_i,
  input  logic [VLEN-1:0] vec_a_i,
  input  logic [VLEN-1:0] vec_b_i,
  input  logic [VLEN-1:0] vec_c_i,
  output logic [VLEN-1:0] result_o,
  output logic            done_o,
  input  logic            ack_i,
  output logic            err_o
`ifdef VMAC_SAT_EN
  ,
  output logic            sat_o
`endif
);

  localparam int unsigned SLICE = VLEN / BEATS;
  localparam int unsigned LANES = SLICE / ELEMENT_WIDTH;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_e                       state_q, state_d;
  logic [BEATS-1:0][SLICE-1:0]  a_q, b_q, c_q, res_q;
  logic [BW-1:0]                beat_q;
  logic                         last_q;
  logic                         err_q;
  sew_e                         sew_q;
  op_e                          op_q;
  logic                         accept, bad_accept;
  logic [SLICE-1:0]             cur_a, cur_b, cur_c, lane_res;
`ifdef VMAC_SAT_EN
  logic [LANES-1:0]             lane_sat;
  logic                         sat_q;
`endif

  assign accept     = (state_q == IDLE) && start_i && (sew_e'(sew_i) != SEW_RSVD);
  assign bad_accept = (state_q == IDLE) && start_i && (sew_e'(sew_i) == SEW_RSVD);

  assign cur_a = a_q[beat_q];
  assign cur_b = b_q[beat_q];
  assign cur_c = c_q[beat_q];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    vmac_lane u_lane (
      .a_i   (cur_a[g*MAX_SEW +: MAX_SEW]),
      .b_i   (cur_b[g*MAX_SEW +: MAX_SEW]),
      .c_i   (cur_c[g*MAX_SEW +: MAX_SEW]),
      .sew_i (sew_q),
      .op_i  (op_q),
      .res_o (lane_res[g*MAX_SEW +: MAX_SEW])
`ifdef VMAC_SAT_EN
      ,
      .sat_o (lane_sat[g])
`endif
    );
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (last_q) state_d = DONE;
      DONE:    if (ack_i)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // last_q marks the final slice as written; the following BUSY cycle moves to DONE,
  // which places done_o BEATS+1 cycles after the accept edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      beat_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      res_q   <= '0;
      sew_q   <= SEW32;
      op_q    <= VMACC;
`ifdef VMAC_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      err_q   <= bad_accept;
      if (accept) begin
        a_q    <= vec_a_i;
        b_q    <= vec_b_i;
        c_q    <= vec_c_i;
        sew_q  <= sew_e'(sew_i);
        op_q   <= op_e'(op_i);
        beat_q <= '0;
        last_q <= 1'b0;
`ifdef VMAC_SAT_EN
        sat_q  <= 1'b0;
`endif
      end else if (state_q == BUSY && !last_q) begin
        res_q[beat_q] <= lane_res;
        beat_q        <= beat_q + BW'(1);
        last_q        <= (beat_q == BW'(BEATS - 1));
`ifdef VMAC_SAT_EN
        sat_q         <= sat_q | (|lane_sat);
`endif
      end
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign done_o   = (state_q == DONE);
  assign err_o    = err_q;
  assign result_o = res_q;
`ifdef VMAC_SAT_EN
  assign sat_o    = sat_q && (state_q == DONE);
`endif

endmodule

// File: tb/tb_vmac_pipe.sv
// Directed vector bench for vmac_pipe; also builds with VMAC_SAT_EN defined.
module tb_vmac_pipe;
  import vmac_pkg::*;

  localparam int unsigned VLEN = 256;

  logic            clk_i = 1'b0;
  logic            rst_i, start_i, ack_i, op_i;
  logic [1:0]      sew_i;
  logic [VLEN-1:0] vec_a_i, vec_b_i, vec_c_i, result_o;
  logic            ready_o, done_o, err_o;
`ifdef VMAC_SAT_EN
  logic            sat_o;
`endif

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  typedef struct {
    logic [1:0]      sew;
    logic            op;
    logic [VLEN-1:0] a, b, c, exp;
    logic            sat;
  } vec_t;

  vmac_pipe #(.VLEN(VLEN), .BEATS(4), .ELEMENT_WIDTH(32)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .ready_o  (ready_o),
    .sew_i    (sew_i),
    .op_i     (op_i),
    .vec_a_i  (vec_a_i),
    .vec_b_i  (vec_b_i),
    .vec_c_i  (vec_c_i),
    .result_o (result_o),
    .done_o   (done_o),
    .ack_i    (ack_i),
    .err_o    (err_o)
`ifdef VMAC_SAT_EN
    ,
    .sat_o    (sat_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic chk(input string nm, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_b(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  function automatic logic [VLEN-1:0] rep32(input logic [31:0] w);
    return {8{w}};
  endfunction

  function automatic vec_t mk(input logic [1:0] s, input logic o, input logic [VLEN-1:0] a,
                              input logic [VLEN-1:0] b, input logic [VLEN-1:0] c,
                              input logic [VLEN-1:0] e, input logic st);
    vec_t v;
    v.sew = s; v.op = o; v.a = a; v.b = b; v.c = c; v.exp = e; v.sat = st;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    string nm;
    int    cyc;
    nm = $sformatf("vec%0d", idx);
    chk_b({nm, "_ready"}, ready_o, 1'b1);
    start_i = 1'b1; sew_i = v.sew; op_i = v.op;
    vec_a_i = v.a; vec_b_i = v.b; vec_c_i = v.c;
    tick;
    start_i = 1'b0;
    vec_a_i = ~v.a; vec_b_i = ~v.b; vec_c_i = v.c ^ rep32(32'h5a5a_5a5a);
    sew_i = 2'($urandom); op_i = ~v.op;
    cyc = 0;
    while (!done_o && cyc < 20) begin
      tick;
      cyc++;
    end
    chk({nm, "_latency"}, VLEN'(cyc), VLEN'(5));
    chk({nm, "_result"}, result_o, v.exp);
`ifdef VMAC_SAT_EN
    chk_b({nm, "_sat"}, sat_o, v.sat);
`endif
    tick;
    chk_b({nm, "_done_held"}, done_o, 1'b1);
    chk({nm, "_result_held"}, result_o, v.exp);
    ack_i = 1'b1;
    tick;
    ack_i = 1'b0;
    chk_b({nm, "_ack_ready"}, ready_o, 1'b1);
    chk_b({nm, "_ack_done"}, done_o, 1'b0);
  endtask

  initial begin
    vec_t            tbl[$];
    logic [VLEN-1:0] last_exp;
    logic            seen;
    int              cyc;

    rst_i = 1'b1; start_i = 1'b0; ack_i = 1'b0; op_i = 1'b0; sew_i = 2'd2;
    vec_a_i = '0; vec_b_i = '0; vec_c_i = '0;

`ifdef VMAC_SAT_EN
    tbl.push_back(mk(2'd2, 1'b0, rep32(32'd3), rep32(32'd5), rep32(32'd7), rep32(32'h16), 1'b0));
    tbl.push_back(mk(2'd0, 1'b1, rep32(32'h10101010), rep32(32'h10101010), rep32(32'h05050505),
                     rep32(32'h80808080), 1'b1));
    tbl.push_back(mk(2'd1, 1'b0, rep32(32'h7FFF7FFF), rep32(32'h00020002), rep32(32'h00010001),
                     rep32(32'h7FFF7FFF), 1'b1));
    tbl.push_back(mk(2'd0, 1'b0, rep32(32'h01020304), rep32(32'h05060708), rep32(32'h10203040),
                     rep32(32'h152C4560), 1'b0));
`else
    tbl.push_back(mk(2'd2, 1'b0, rep32(32'd3), rep32(32'd5), rep32(32'd7), rep32(32'h16), 1'b0));
    tbl.push_back(mk(2'd0, 1'b1, rep32(32'h10101010), rep32(32'h10101010), rep32(32'h05050505),
                     rep32(32'h05050505), 1'b0));
    tbl.push_back(mk(2'd1, 1'b0, rep32(32'hFFFFFFFF), rep32(32'h00020002), rep32(32'h00010001),
                     rep32(32'hFFFFFFFF), 1'b0));
    tbl.push_back(mk(2'd2, 1'b1, rep32(32'd2), rep32(32'd3), rep32(32'd1), rep32(32'hFFFFFFFB), 1'b0));
    tbl.push_back(mk(2'd0, 1'b0, rep32(32'h01020304), rep32(32'h05060708), rep32(32'h10203040),
                     rep32(32'h152C4560), 1'b0));
    tbl.push_back(mk(2'd1, 1'b0, rep32(32'h00030100), rep32(32'h00040100), rep32(32'h00050001),
                     rep32(32'h00110001), 1'b0));
    tbl.push_back(mk(2'd2, 1'b0, rep32(32'hFFFFFFFF), rep32(32'hFFFFFFFF), rep32(32'd0),
                     rep32(32'd1), 1'b0));
    tbl.push_back(mk(2'd0, 1'b1, rep32(32'd3), rep32(32'd4), rep32(32'd0), rep32(32'h000000F4), 1'b0));
    tbl.push_back(mk(2'd2, 1'b0,
                     {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1},
                     rep32(32'h10),
                     {32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0},
                     {32'h87, 32'h76, 32'h65, 32'h54, 32'h43, 32'h32, 32'h21, 32'h10}, 1'b0));
    tbl.push_back(mk(2'd1, 1'b1, rep32(32'h00020003), rep32(32'h00040005), rep32(32'h00100000),
                     rep32(32'h0008FFF1), 1'b0));
`endif

    repeat (3) tick;
    rst_i = 1'b0;
    tick;
    chk_b("reset_ready", ready_o, 1'b1);
    chk_b("reset_done", done_o, 1'b0);
    chk_b("reset_err", err_o, 1'b0);
    chk("reset_result", result_o, '0);

    foreach (tbl[i]) run_vec(tbl[i], i);
    last_exp = tbl[tbl.size() - 1].exp;

    // Reserved SEW: error pulse only, no state change, result untouched.
    start_i = 1'b1; sew_i = 2'd3; op_i = 1'b0;
    vec_a_i = rep32(32'd9); vec_b_i = rep32(32'd9); vec_c_i = rep32(32'd9);
    tick;
    start_i = 1'b0; sew_i = 2'd2;
    chk_b("rsvd_err_pulse", err_o, 1'b1);
    chk_b("rsvd_ready", ready_o, 1'b1);
    chk("rsvd_result", result_o, last_exp);
    tick;
    chk_b("rsvd_err_clear", err_o, 1'b0);
    chk_b("rsvd_still_idle", ready_o, 1'b1);

    // start_i held through BUSY/DONE with changing operands, then ack with start.
    start_i = 1'b1; sew_i = 2'd2; op_i = 1'b0;
    vec_a_i = rep32(32'd3); vec_b_i = rep32(32'd5); vec_c_i = rep32(32'd7);
    tick;
    cyc = 0;
    while (!done_o && cyc < 20) begin
      vec_a_i = {8{$urandom}};
      vec_c_i = {8{$urandom}};
      tick;
      cyc++;
    end
    chk("held_latency", VLEN'(cyc), VLEN'(5));
    chk("held_result", result_o, rep32(32'h16));
    ack_i = 1'b1;
    tick;
    ack_i = 1'b0; start_i = 1'b0;
    chk_b("ack_start_not_accepted", ready_o, 1'b1);
    seen = 1'b0;
    repeat (8) begin
      tick;
      seen = seen | done_o;
    end
    chk_b("ack_start_no_second_done", seen, 1'b0);
    chk("ack_start_result_kept", result_o, rep32(32'h16));

    // Reset during BUSY aborts the operation.
    start_i = 1'b1; sew_i = 2'd2; op_i = 1'b0;
    vec_a_i = rep32(32'd3); vec_b_i = rep32(32'd5); vec_c_i = rep32(32'd7);
    tick;
    start_i = 1'b0;
    tick;
    tick;
    chk_b("abort_busy", ready_o, 1'b0);
    rst_i = 1'b1;
    #1;
    chk("abort_result_async", result_o, '0);
    chk_b("abort_done_async", done_o, 1'b0);
    tick;
    rst_i = 1'b0;
    tick;
    chk_b("abort_ready", ready_o, 1'b1);
    seen = 1'b0;
    repeat (8) begin
      tick;
      seen = seen | done_o;
    end
    chk_b("abort_no_done", seen, 1'b0);
    chk("abort_result", result_o, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
